// File: rtl/dqs_burst_ctrl.sv
// DQS strobe controller: write preamble/burst/postamble sequencing on shared pads,
// plus per-lane rising-edge counting over a fixed read window. 1-cycle start latency.
module dqs_burst_ctrl #(
  parameter int NUM_LANES   = 2,
  parameter int BURST_LEN   = 8,
  parameter int PRE_CYCLES  = 1,
  parameter int POST_CYCLES = 1,
  parameter int RD_WINDOW   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_start,
  input  logic                 rd_start,
  output logic                 busy,
  output logic                 wr_done,
  output logic                 rd_done,
  output logic [NUM_LANES-1:0] rd_err,
  output logic [NUM_LANES-1:0] dqs_data,
  output logic [NUM_LANES-1:0] dqs_tri,
  input  logic [NUM_LANES-1:0] dqs_received
);

  localparam int MAXP = (BURST_LEN > RD_WINDOW) ? BURST_LEN : RD_WINDOW;
  localparam int PW   = $clog2(MAXP) + 1;
  localparam int CW   = $clog2(BURST_LEN) + 1;

  localparam logic [PW-1:0] PH_ONE     = PW'(1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRE_CYCLES - 1);
  localparam logic [PW-1:0] BURST_LAST = PW'(BURST_LEN - 1);
  localparam logic [PW-1:0] POST_LAST  = PW'(POST_CYCLES - 1);
  localparam logic [PW-1:0] RD_LAST    = PW'(RD_WINDOW - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_EXP    = CW'(BURST_LEN / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_BURST,
    S_POST,
    S_RD_WIN
  } state_t;

  state_t                       state_q;
  logic [PW-1:0]                phase_q;
  logic [NUM_LANES-1:0]         samp_q;
  logic [NUM_LANES-1:0][CW-1:0] cnt_q;
  logic [NUM_LANES-1:0][CW-1:0] cnt_d;
  logic [NUM_LANES-1:0]         rise_d;
  logic [NUM_LANES-1:0]         err_d;
  logic                         data_q;
  logic                         tri_q;
  logic                         busy_q;
  logic                         wr_done_q;
  logic                         rd_done_q;
  logic [NUM_LANES-1:0]         rd_err_q;

  // Edge counters saturate; the error verdict uses the count including this cycle's edge.
  always_comb begin
    rise_d = dqs_received & ~samp_q;
    cnt_d  = cnt_q;
    err_d  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rise_d[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
      err_d[i] = (cnt_d[i] != CNT_EXP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      samp_q    <= '0;
      cnt_q     <= '0;
      data_q    <= 1'b0;
      tri_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_err_q  <= '0;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_start) begin
            state_q <= S_PRE;
            phase_q <= '0;
            tri_q   <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (rd_start) begin
            state_q <= S_RD_WIN;
            phase_q <= '0;
            samp_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_PRE: begin
          if (phase_q == PRE_LAST) begin
            state_q <= S_BURST;
            phase_q <= '0;
            data_q  <= 1'b1;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        S_BURST: begin
          if (phase_q == BURST_LAST) begin
            state_q <= S_POST;
            phase_q <= '0;
            data_q  <= 1'b0;
          end else begin
            phase_q <= phase_q + PH_ONE;
            data_q  <= ~data_q;
          end
        end
        S_POST: begin
          if (phase_q == POST_LAST) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            tri_q     <= 1'b1;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        S_RD_WIN: begin
          samp_q <= dqs_received;
          cnt_q  <= cnt_d;
          if (phase_q == RD_LAST) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            rd_err_q  <= err_d;
            rd_done_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          phase_q <= '0;
          tri_q   <= 1'b1;
          data_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign wr_done  = wr_done_q;
  assign rd_done  = rd_done_q;
  assign rd_err   = rd_err_q;
  assign dqs_data = {NUM_LANES{data_q}};
  assign dqs_tri  = {NUM_LANES{tri_q}};

endmodule

// File: tb/tb_dqs_burst_ctrl.sv
// Bench for dqs_burst_ctrl: default instance and a 4-lane short-burst instance driven
// in lockstep, checked cycle by cycle against a timeline/edge-count reference model.
module tb_dqs_burst_ctrl;

  localparam int A_PRE = 1, A_BL = 8, A_POST = 1;
  localparam int B_PRE = 2, B_BL = 4, B_POST = 2;
  localparam int WIN   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_start = 1'b0;
  logic rd_start = 1'b0;

  logic       a_busy, a_wr_done, a_rd_done;
  logic [1:0] a_rd_err, a_data, a_tri;
  logic [1:0] a_rcv = '0;
  logic       b_busy, b_wr_done, b_rd_done;
  logic [3:0] b_rd_err, b_data, b_tri;
  logic [3:0] b_rcv = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dqs_burst_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .rd_start(rd_start),
    .busy(a_busy), .wr_done(a_wr_done), .rd_done(a_rd_done), .rd_err(a_rd_err),
    .dqs_data(a_data), .dqs_tri(a_tri), .dqs_received(a_rcv)
  );

  dqs_burst_ctrl #(
    .NUM_LANES(4), .BURST_LEN(B_BL), .PRE_CYCLES(B_PRE), .POST_CYCLES(B_POST), .RD_WINDOW(WIN)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .rd_start(rd_start),
    .busy(b_busy), .wr_done(b_wr_done), .rd_done(b_rd_done), .rd_err(b_rd_err),
    .dqs_data(b_data), .dqs_tri(b_tri), .dqs_received(b_rcv)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write timeline: cycle k after the start is taken; pad driven for pre+bl+post cycles.
  function automatic bit drive_exp(int k, int pre, int bl, int post);
    return (k >= 0) && (k < pre + bl + post);
  endfunction

  function automatic bit data_exp(int k, int pre, int bl);
    return (k >= pre) && (k < pre + bl) && (((k - pre) % 2) == 0);
  endfunction

  // Read model: bit t is the pad level seen at window edge t+1; level starts low.
  function automatic int rises(bit [WIN-1:0] p);
    int n = 0;
    bit prev = 1'b0;
    for (int t = 0; t < WIN; t++) begin
      if (p[t] && !prev) n++;
      prev = p[t];
    end
    return n;
  endfunction

  function automatic bit [WIN-1:0] pulses(int k);
    bit [WIN-1:0] p = '0;
    for (int j = 0; j < k; j++) p[2*j+1] = 1'b1;
    return p;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_a_tri"}, 32'(a_tri), 32'h3);
    check({tag, "_b_tri"}, 32'(b_tri), 32'hF);
    check({tag, "_a_data"}, 32'(a_data), 32'h0);
    check({tag, "_b_data"}, 32'(b_data), 32'h0);
    check({tag, "_a_busy"}, 32'(a_busy), 32'h0);
    check({tag, "_b_busy"}, 32'(b_busy), 32'h0);
  endtask

  task automatic run_write(input bit with_rd, input bit noise);
    bit da, db;
    @(posedge clk); #1 wr_start = 1'b1; rd_start = with_rd;
    @(posedge clk); #1 wr_start = 1'b0; rd_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      da = drive_exp(k, A_PRE, A_BL, A_POST);
      db = drive_exp(k, B_PRE, B_BL, B_POST);
      check("wr_a_tri", 32'(a_tri), da ? 32'h0 : 32'h3);
      check("wr_a_data", 32'(a_data), data_exp(k, A_PRE, A_BL) ? 32'h3 : 32'h0);
      check("wr_a_busy", 32'(a_busy), 32'(da));
      check("wr_a_done", 32'(a_wr_done), 32'(k == A_PRE + A_BL + A_POST));
      check("wr_a_rd_done", 32'(a_rd_done), 32'h0);
      check("wr_b_tri", 32'(b_tri), db ? 32'h0 : 32'hF);
      check("wr_b_data", 32'(b_data), data_exp(k, B_PRE, B_BL) ? 32'hF : 32'h0);
      check("wr_b_busy", 32'(b_busy), 32'(db));
      check("wr_b_done", 32'(b_wr_done), 32'(k == B_PRE + B_BL + B_POST));
      check("wr_b_rd_done", 32'(b_rd_done), 32'h0);
      wr_start = noise && (k == 3);
      rd_start = noise && (k == 3);
      @(posedge clk); #1;
    end
    wr_start = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic run_read(input bit [2*WIN-1:0] pa, input bit [4*WIN-1:0] pb);
    logic [1:0] ea;
    logic [3:0] eb;
    for (int i = 0; i < 2; i++) ea[i] = (rises(pa[i*WIN +: WIN]) != A_BL / 2);
    for (int i = 0; i < 4; i++) eb[i] = (rises(pb[i*WIN +: WIN]) != B_BL / 2);
    @(posedge clk); #1 rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    for (int t = 0; t < WIN; t++) begin
      check("rd_a_busy", 32'(a_busy), 32'h1);
      check("rd_b_busy", 32'(b_busy), 32'h1);
      check("rd_a_tri", 32'(a_tri), 32'h3);
      check("rd_b_tri", 32'(b_tri), 32'hF);
      check("rd_a_done_early", 32'(a_rd_done), 32'h0);
      check("rd_b_done_early", 32'(b_rd_done), 32'h0);
      for (int i = 0; i < 2; i++) a_rcv[i] = pa[i*WIN + t];
      for (int i = 0; i < 4; i++) b_rcv[i] = pb[i*WIN + t];
      @(posedge clk); #1;
    end
    a_rcv = '0;
    b_rcv = '0;
    check("rd_a_done", 32'(a_rd_done), 32'h1);
    check("rd_b_done", 32'(b_rd_done), 32'h1);
    check("rd_a_err", 32'(a_rd_err), 32'(ea));
    check("rd_b_err", 32'(b_rd_err), 32'(eb));
    check("rd_a_busy_end", 32'(a_busy), 32'h0);
    check("rd_b_busy_end", 32'(b_busy), 32'h0);
    @(posedge clk); #1;
    check("rd_a_done_pulse", 32'(a_rd_done), 32'h0);
    check("rd_b_done_pulse", 32'(b_rd_done), 32'h0);
    check("rd_a_err_hold", 32'(a_rd_err), 32'(ea));
    check("rd_b_err_hold", 32'(b_rd_err), 32'(eb));
  endtask

  function automatic bit [WIN-1:0] rand_lane(int half);
    if ($urandom_range(0, 1) == 1) return pulses(half - 1 + int'($urandom_range(0, 2)));
    return WIN'($urandom);
  endfunction

  initial begin
    bit [2*WIN-1:0] pa;
    bit [4*WIN-1:0] pb;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_a_err", 32'(a_rd_err), 32'h0);
    check("reset_b_err", 32'(b_rd_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");

    run_write(1'b0, 1'b0);
    run_read({pulses(4), pulses(4)}, {pulses(2), pulses(2), pulses(2), pulses(2)});
    run_read({pulses(3), pulses(4)}, {pulses(2), pulses(1), pulses(3), pulses(2)});

    run_write(1'b1, 1'b0);
    run_write(1'b0, 1'b1);

    @(posedge clk); #1 wr_start = 1'b1;
    @(posedge clk); #1 wr_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("midrst_a_driving", 32'(a_tri), 32'h0);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst_a_err", 32'(a_rd_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      check("midrst_a_no_done", 32'(a_wr_done), 32'h0);
      check("midrst_b_no_done", 32'(b_wr_done), 32'h0);
      check("midrst_a_tri", 32'(a_tri), 32'h3);
    end
    run_write(1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 2; i++) pa[i*WIN +: WIN] = rand_lane(A_BL / 2);
      for (int i = 0; i < 4; i++) pb[i*WIN +: WIN] = rand_lane(B_BL / 2);
      run_read(pa, pb);
      if ($urandom_range(0, 1) == 1) run_write(1'b0, $urandom_range(0, 1) == 1);
    end

    repeat (2) @(posedge clk);
    #1;
    check_idle("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
